// File: rtl/hf_reader_sequencer_pkg.sv
// Shared mode constants, Miller sequence and sequencer state types for the
// ISO14443-A reader path.
package hf_reader_sequencer_pkg;

    localparam logic [2:0] SNIFFER       = 3'b000;
    localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;

    typedef enum logic [1:0] {X, Y, Z} miller_seq_t;

    typedef enum logic [2:0] {IDLE, SOF, DATA, EOF, GUARD, LISTEN} seq_state_t;

    // Modified Miller: a 1 is always X; a 0 is Y after a 1, otherwise Z.
    function automatic miller_seq_t miller_encode(input logic bit_val, input logic prev_bit);
        if (bit_val) return X;
        return prev_bit ? Y : Z;
    endfunction

    function automatic logic miller_pause(input miller_seq_t seq, input int unsigned phase,
                                          input int unsigned bit_len, input int unsigned pause_len);
        case (seq)
            Z:       return phase < pause_len;
            X:       return (phase >= bit_len / 2) && (phase < bit_len / 2 + pause_len);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hf_reader_sequencer_fifo.sv
// Byte FIFO feeding the reader sequencer; first-word-fall-through read port,
// push and pop may happen in the same cycle.
module hf_byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_source,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(negedge clk_source) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(negedge clk_source) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hf_reader_sequencer.sv
// Reader frame sequencer: Modified Miller transmit at 106 kbit/s, guard time,
// then a bounded listen window on the 848 kHz detector output.
module hf_reader_sequencer
    import hf_reader_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BIT_LEN    = 128,
    parameter int unsigned PAUSE_LEN  = 32,
    parameter int unsigned GUARD_LEN  = 1172,
    parameter int unsigned QUIET_LEN  = 256
) (
    input  logic        ck_1356meg,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  last_bits,
    input  logic        start,
    input  logic [15:0] listen_cycles,
    input  logic        curbit,
    output logic        mod_sig,
    output logic [2:0]  mod_type,
    output logic        rx_window,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        resp_seen,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        overflow
);
    localparam int unsigned PH_W  = $clog2(BIT_LEN);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned Q_W   = $clog2(QUIET_LEN + 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BIT_LEN - 1);
    localparam logic [15:0]      GUARD_LAST = 16'(GUARD_LEN - 1);
    localparam logic [Q_W-1:0]   QUIET_LAST = Q_W'(QUIET_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_LEFT   = CNT_W'(1);

    seq_state_t  state_q, state_d;
    miller_seq_t seq_q, seq_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       last_idx_q, last_idx_d;
    logic             last_byte_q, last_byte_d;
    logic [7:0]       shift_q, shift_d;
    logic             prev_bit_q, prev_bit_d;
    logic             eof_tail_q, eof_tail_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [Q_W-1:0]   quiet_q, quiet_d;
    logic [2:0]       last_bits_q, last_bits_d;
    logic [15:0]      listen_q, listen_d;
    logic             resp_d, done_d, timeout_d;
    logic             start_ok, pop, load_byte, send_bit, tx_d;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;

    hf_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_source (ck_1356meg),
        .rst        (rst),
        .push       (wr_en),
        .push_data  (wr_data),
        .pop        (pop),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign rx_window = (state_q == LISTEN);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        last_idx_d  = last_idx_q;
        last_byte_d = last_byte_q;
        shift_d     = shift_q;
        prev_bit_d  = prev_bit_q;
        eof_tail_d  = eof_tail_q;
        cnt_d       = cnt_q;
        quiet_d     = quiet_q;
        last_bits_d = last_bits_q;
        listen_d    = listen_q;
        resp_d      = resp_seen;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        start_ok    = 1'b0;
        pop         = 1'b0;
        load_byte   = 1'b0;
        send_bit    = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (start && !fifo_empty) begin
                    start_ok    = 1'b1;
                    state_d     = SOF;
                    seq_d       = Z;
                    prev_bit_d  = 1'b0;
                    resp_d      = 1'b0;
                    last_bits_d = last_bits;
                    listen_d    = listen_cycles;
                end
            end
            SOF: begin
                if (phase_q == PH_LAST) load_byte = 1'b1;
            end
            DATA: begin
                if (phase_q == PH_LAST) begin
                    if (bit_idx_q != last_idx_q) begin
                        send_bit   = shift_q[0];
                        shift_d    = shift_q >> 1;
                        bit_idx_d  = bit_idx_q + 1'b1;
                        seq_d      = miller_encode(send_bit, prev_bit_q);
                        prev_bit_d = send_bit;
                    end else if (last_byte_q) begin
                        state_d    = EOF;
                        eof_tail_d = 1'b0;
                        seq_d      = miller_encode(1'b0, prev_bit_q);
                    end else begin
                        load_byte = 1'b1;
                    end
                end
            end
            EOF: begin
                if (phase_q == PH_LAST) begin
                    if (!eof_tail_q) begin
                        eof_tail_d = 1'b1;
                        seq_d      = Y;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = '0;
                    end
                end
            end
            GUARD: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GUARD_LAST) begin
                    if (listen_q == '0) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = LISTEN;
                        cnt_d   = listen_q;
                        quiet_d = '0;
                    end
                end
            end
            LISTEN: begin
                // Once a response is seen the window is closed by silence only.
                if (curbit) begin
                    resp_d  = 1'b1;
                    quiet_d = '0;
                end else if (resp_seen) begin
                    if (quiet_q == QUIET_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        quiet_d = quiet_q + 1'b1;
                    end
                end else if (cnt_q <= 16'd1) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte boundary: the pop that empties the FIFO marks the frame's last byte.
        if (load_byte) begin
            pop         = 1'b1;
            state_d     = DATA;
            bit_idx_d   = '0;
            send_bit    = fifo_head[0];
            shift_d     = {1'b0, fifo_head[7:1]};
            last_byte_d = (fifo_count == ONE_LEFT) && !wr_en;
            last_idx_d  = last_byte_d ? last_bits_q - 3'd1 : 3'd7;
            seq_d       = miller_encode(send_bit, prev_bit_q);
            prev_bit_d  = send_bit;
        end

        tx_d = (state_d == SOF) || (state_d == DATA) || (state_d == EOF);
    end

    always_ff @(negedge ck_1356meg) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_q       <= Y;
            phase_q     <= '0;
            bit_idx_q   <= '0;
            last_idx_q  <= '0;
            last_byte_q <= 1'b0;
            shift_q     <= '0;
            prev_bit_q  <= 1'b0;
            eof_tail_q  <= 1'b0;
            cnt_q       <= '0;
            quiet_q     <= '0;
            last_bits_q <= '0;
            listen_q    <= '0;
            mod_sig     <= 1'b0;
            mod_type    <= READER_LISTEN;
            done        <= 1'b0;
            timeout     <= 1'b0;
            resp_seen   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            last_idx_q  <= last_idx_d;
            last_byte_q <= last_byte_d;
            shift_q     <= shift_d;
            prev_bit_q  <= prev_bit_d;
            eof_tail_q  <= eof_tail_d;
            cnt_q       <= cnt_d;
            quiet_q     <= quiet_d;
            last_bits_q <= last_bits_d;
            listen_q    <= listen_d;
            mod_sig     <= tx_d && miller_pause(seq_d, 32'(phase_d), BIT_LEN, PAUSE_LEN);
            mod_type    <= tx_d ? READER_MOD : READER_LISTEN;
            done        <= done_d;
            timeout     <= timeout_d;
            resp_seen   <= resp_d;
            if (wr_en && fifo_full) overflow <= 1'b1;
            else if (start_ok)      overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hf_reader_sequencer.sv
// Self-checking bench for hf_reader_sequencer: directed and random frames checked
// against a slot-level Modified Miller / listen-window reference model.
module tb_hf_reader_sequencer;

    typedef logic [7:0] bq_t[$];
    typedef int iq_t[$];

    logic        ck_1356meg = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  last_bits = '0;
    logic        start = 1'b0;
    logic [15:0] listen_cycles = '0;
    logic        curbit = 1'b0;
    logic        mod_sig, rx_window, busy, done, timeout, resp_seen;
    logic        fifo_full, fifo_empty, overflow;
    logic [2:0]  mod_type;

    int total = 0;
    int bad   = 0;

    hf_reader_sequencer #(
        .FIFO_DEPTH (8),
        .BIT_LEN    (128),
        .PAUSE_LEN  (32),
        .GUARD_LEN  (1172),
        .QUIET_LEN  (256)
    ) dut (
        .ck_1356meg    (ck_1356meg),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .last_bits     (last_bits),
        .start         (start),
        .listen_cycles (listen_cycles),
        .curbit        (curbit),
        .mod_sig       (mod_sig),
        .mod_type      (mod_type),
        .rx_window     (rx_window),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .resp_seen     (resp_seen),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .overflow      (overflow)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    // DUT updates on negedge; sample and drive half a cycle away.
    task automatic tick();
        @(posedge ck_1356meg);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pause start offset per slot (-1: no pause): SOF Z, data bits, EOF 0, Y.
    function automatic iq_t frame_model(input bq_t bytes, input int lb);
        iq_t offs;
        int prev = 0;
        int n;
        int b;
        logic [7:0] cur;
        offs.push_back(0);
        for (int i = 0; i < bytes.size(); i++) begin
            n   = (i == bytes.size() - 1) ? ((lb == 0) ? 8 : lb) : 8;
            cur = bytes[i];
            for (int j = 0; j < n; j++) begin
                b = cur[j] ? 1 : 0;
                offs.push_back(b ? 64 : (prev ? -1 : 0));
                prev = b;
            end
        end
        offs.push_back(prev ? -1 : 0);
        offs.push_back(-1);
        return offs;
    endfunction

    function automatic logic [127:0] slot_vec(input int off);
        logic [127:0] v = '0;
        if (off >= 0)
            for (int c = off; c < off + 32; c++) v[c] = 1'b1;
        return v;
    endfunction

    // Runs one frame already loaded into the FIFO; r<0 means no response.
    task automatic run_frame(input string name, input bq_t bytes, input int lb, input int listen,
                             input int r, input int p, input int mid_start);
        iq_t offs;
        logic [127:0] obs [80];
        int F, W, E;
        int fr_bad = 0, gd_bad = 0, win_bad = 0;
        logic exp_done;

        offs = frame_model(bytes, lb);
        F = offs.size() * 128;
        W = F + 1172;
        exp_done = (r >= 0);
        E = exp_done ? (W + r + p + 256) : (W + listen);

        last_bits     = 3'(lb);
        listen_cycles = 16'(listen);
        start         = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_start_busy"}, 128'(busy), 128'(1'b1));
        check({name, "_start_ovf"}, 128'(overflow), 128'(1'b0));
        check({name, "_start_resp"}, 128'(resp_seen), 128'(1'b0));

        for (int s = 0; s <= E; s++) begin
            if (s < F) begin
                obs[s / 128][s % 128] = mod_sig;
                if (mod_type !== 3'b100 || busy !== 1'b1 || rx_window !== 1'b0) fr_bad++;
            end else if (s < W) begin
                if (mod_type !== 3'b011 || mod_sig !== 1'b0 || rx_window !== 1'b0 || busy !== 1'b1)
                    gd_bad++;
            end else if (s < E) begin
                if (rx_window !== 1'b1 || done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1 ||
                    mod_type !== 3'b011 || mod_sig !== 1'b0) win_bad++;
            end
            if (exp_done && s == W + r + 1)
                check({name, "_resp_rise"}, 128'(resp_seen), 128'(1'b1));
            start  = (s == mid_start);
            curbit = exp_done && (s >= W + r) && (s < W + r + p);
            if (s < E) tick();
        end
        start  = 1'b0;
        curbit = 1'b0;

        for (int i = 0; i < offs.size(); i++)
            check($sformatf("%s_slot%0d", name, i), obs[i], slot_vec(offs[i]));
        check({name, "_frame_modtype"}, 128'(fr_bad), 128'(0));
        check({name, "_guard"}, 128'(gd_bad), 128'(0));
        check({name, "_window"}, 128'(win_bad), 128'(0));
        check({name, "_close_rx"}, 128'(rx_window), 128'(1'b0));
        check({name, "_close_done"}, 128'(done), 128'(exp_done));
        check({name, "_close_timeout"}, 128'(timeout), 128'(!exp_done));
        check({name, "_close_busy"}, 128'(busy), 128'(1'b0));
        check({name, "_close_resp"}, 128'(resp_seen), 128'(exp_done));
        tick();
        check({name, "_pulse_done"}, 128'(done), 128'(1'b0));
        check({name, "_pulse_timeout"}, 128'(timeout), 128'(1'b0));
        check({name, "_resp_hold"}, 128'(resp_seen), 128'(exp_done));
        check({name, "_fifo_empty"}, 128'(fifo_empty), 128'(1'b1));
    endtask

    initial begin
        bq_t q;
        int n, lb, listen, r, p;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_mod_sig", 128'(mod_sig), 128'(1'b0));
        check("rst_mod_type", 128'(mod_type), 128'(3'b011));
        check("rst_rx_window", 128'(rx_window), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_timeout", 128'(timeout), 128'(1'b0));
        check("rst_resp", 128'(resp_seen), 128'(1'b0));
        check("rst_overflow", 128'(overflow), 128'(1'b0));
        check("rst_fifo_empty", 128'(fifo_empty), 128'(1'b1));
        check("rst_fifo_full", 128'(fifo_full), 128'(1'b0));

        // Start with an empty FIFO must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_start_busy", 128'(busy), 128'(1'b0));
        check("empty_start_mod", 128'(mod_sig), 128'(1'b0));
        repeat (5) tick();
        check("empty_start_busy2", 128'(busy), 128'(1'b0));

        // REQA with timeout; extra start mid-frame must be ignored.
        q = {8'h26};
        push(8'h26);
        run_frame("reqa", q, 7, 500, -1, 0, 300);

        // Response 100 cycles into the window.
        q = {8'h93, 8'h20};
        foreach (q[i]) push(q[i]);
        run_frame("resp", q, 0, 1000, 100, 1, -1);

        // Response on the last counter cycle still wins over expiry.
        q = {8'h52};
        push(8'h52);
        run_frame("resp_edge", q, 7, 200, 199, 3, -1);

        // Overflow: ninth write dropped.
        q = {};
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'($urandom);
            if (i < 8) q.push_back(wr_data);
            push(wr_data);
            if (i == 7) begin
                check("ovf_full8", 128'(fifo_full), 128'(1'b1));
                check("ovf_clear8", 128'(overflow), 128'(1'b0));
            end
        end
        check("ovf_set", 128'(overflow), 128'(1'b1));
        run_frame("ovf", q, 3, 300, -1, 0, -1);

        // Zero-length window times out immediately.
        q = {8'hA5};
        push(8'hA5);
        run_frame("listen0", q, 0, 0, -1, 0, -1);

        for (int k = 0; k < 5; k++) begin
            q = {};
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            foreach (q[i]) push(q[i]);
            lb     = $urandom_range(0, 7);
            listen = $urandom_range(30, 700);
            p      = $urandom_range(1, 8);
            r      = ($urandom_range(0, 1) == 1) ? $urandom_range(0, listen - 1) : -1;
            run_frame($sformatf("rnd%0d", k), q, lb, listen, r, p, $urandom_range(1, 200));
        end

        // Reset in the middle of a 2-byte frame.
        push(8'h11);
        push(8'h22);
        last_bits = 3'd0;
        listen_cycles = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (400) tick();
        check("midrst_busy_before", 128'(busy), 128'(1'b1));
        rst = 1'b1;
        tick();
        check("midrst_mod_sig", 128'(mod_sig), 128'(1'b0));
        check("midrst_mod_type", 128'(mod_type), 128'(3'b011));
        check("midrst_fifo_empty", 128'(fifo_empty), 128'(1'b1));
        check("midrst_busy", 128'(busy), 128'(1'b0));
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hf_reader_sequencer.md
# hf_reader_sequencer

Reader-side frame sequencer for the ISO14443-A HF path. It buffers command bytes written from the ARM side, encodes them as Modified Miller at 106 kbit/s, and drives the coil pause request (`mod_sig`) and the HF mode select (`mod_type`). After the frame it holds a guard time, then opens a bounded listen window in which it watches the 848 kHz modulation detector output (`curbit`). It sits between the SPI configuration logic and the antenna/ADC datapath, and replaces direct ARM control of `ssp_dout` and `mod_type` during reader exchanges.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: byte buffer entries (power of 2).
- `BIT_LEN`, 128: carrier cycles per bit slot.
- `PAUSE_LEN`, 32: carrier cycles per pause.
- `GUARD_LEN`, 1172: carrier cycles from end of EOF to listen window open.
- `QUIET_LEN`, 256: carrier cycles of `curbit`=0 that end a window once a response has been detected.

Ports:
- `ck_1356meg` in 1: 13.56 MHz carrier clock. All logic runs on negedge, matching the HF datapath.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: push `wr_data` into the FIFO.
- `wr_data` in 8: command byte, sent LSB first.
- `last_bits` in 3: valid bits in the final byte (0 means 8). Sampled on accepted `start`.
- `start` in 1: single-cycle frame request.
- `listen_cycles` in 16: listen window length. Sampled on accepted `start`.
- `curbit` in 1: modulation detected, from the 848 kHz detector.
- `mod_sig` out 1: 1 = drop carrier (pause).
- `mod_type` out 3: 3'b100 (READER_MOD) while transmitting, else 3'b011 (READER_LISTEN).
- `rx_window` out 1: high while in LISTEN.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a window closes after a response.
- `timeout` out 1: one-cycle pulse when a window expires with no response.
- `resp_seen` out 1: response detected in the last window. Held until the next accepted `start`.
- `fifo_full`, `fifo_empty` out 1 each.
- `overflow` out 1: sticky; set when a write arrives while full. Cleared on accepted `start`.

## Operation
- **Reset values:** `mod_sig`=0, `mod_type`=3'b011, `rx_window`=0, `busy`=0, `done`=0, `timeout`=0, `resp_seen`=0, `overflow`=0. FIFO is empty and the state is IDLE.
- **States:** IDLE → SOF → DATA → EOF → GUARD → LISTEN → IDLE.
- **IDLE:** `start` with a non-empty FIFO is accepted. `start` with an empty FIFO, or while `busy`, is ignored.
- **Writes:** accepted in any state when the FIFO is not full. A write while full is dropped and sets `overflow`.
- **Simultaneous write and pop:** both occur. The FIFO count stays unchanged.
- **SOF:** one Z slot. The previous-bit flag is set to 0.
- **DATA bit encoding:**
  - A 1 bit sends X (pause starting at slot phase 64).
  - A 0 bit sends Z (pause at phase 0) if the previous bit was 0, including the SOF case.
  - A 0 bit sends Y (no pause) if the previous bit was 1.
- **Byte handling:** a byte is popped at its first bit slot. The frame's last byte is the one whose pop leaves the FIFO empty; only `last_bits` of its bits are sent. If the FIFO underruns at a byte boundary, the frame ends there by construction.
- **EOF:** a logic 0 (Z or Y per the same rule), then one Y slot.
- **GUARD:** `mod_type` returns to 011 at the first GUARD cycle. The state lasts `GUARD_LEN` cycles.
- **LISTEN:**
  - A down-counter loads `listen_cycles`.
  - The first `curbit`=1 sets `resp_seen`. The window then ends after `QUIET_LEN` consecutive `curbit`=0 cycles → `done`.
  - If the counter reaches 0 with no response → `timeout`.
  - `listen_cycles`=0 ends the window immediately with `timeout`.
  - A response overrides counter expiry.
- **Reset mid-frame:** `rst` mid-frame aborts the frame on the next edge. `mod_sig` goes 0 and the FIFO is flushed.

## Timing
- Accepted `start` at edge N: SOF slot phase 0 at edge N+1, and `mod_sig`=1 from N+1 for exactly `PAUSE_LEN` cycles.
- `mod_sig` is registered with no further delay. The pause edges of consecutive slots land exactly `BIT_LEN` apart.
- Slot phase counter is 7 bits (0..`BIT_LEN`-1) and wraps per slot. A frame of k bits lasts (k+3)·`BIT_LEN` cycles.
- `done` and `timeout` are asserted the cycle after the closing condition, together with `rx_window` falling. `busy` falls on the same cycle.

## Structure
- Shared package holds:
  - the mode constants `SNIFFER`, `TAGSIM_LISTEN`, `TAGSIM_MOD`, `READER_LISTEN`, `READER_MOD`;
  - the Miller sequence enum {X, Y, Z};
  - the sequencer state enum.
- Sub-module `hf_byte_fifo`: synchronous FIFO with full/empty and simultaneous push/pop. It is instantiated once.

## Test plan
- **REQA:** write 0x26, `last_bits`=7, `start`. Pause starts at cycle offsets 0, 128, 320, 448, 640, 832, 1024 from SOF, each 32 cycles wide. `mod_type`=100 for 1280 cycles, then GUARD for 1172 cycles, then `rx_window`=1.
- **Timeout:** `listen_cycles`=500 with `curbit` held 0 → `timeout` pulse 500 cycles after the window opens. `resp_seen`=0, `busy` falls.
- **Response:** `curbit`=1 pulses 100 cycles into the window → window closes 256 quiet cycles after the last 1. `done`=1, `resp_seen`=1.
- **Overflow:** 9 writes with `FIFO_DEPTH`=8 → `fifo_full` after the 8th write and `overflow`=1. The 9th byte is absent from the transmitted frame. The next `start` clears `overflow`.
- **Illegal start:** `start` with an empty FIFO, and `start` while `busy` → no state change and no `mod_sig` activity.
- **Reset:** assert `rst` at cycle 400 of a 2-byte frame → the next cycle shows `mod_sig`=0, `mod_type`=011, `fifo_empty`=1, `busy`=0.
